// File: rtl/slot_reel_engine.sv
// N-reel slot spin/score engine: owns credits, bet, staggered reel stops and payout; optional AUTO_SPIN_EN adds auto-spin.
// Latency: spin accepted next clk; reel i stops on tick SPIN_TICKS+i*STAGGER_TICKS; scoring 2 clks after the last stop.
// Backpressure: none; button pulses outside IDLE are dropped, spin without enough credit is ignored.
module slot_reel_engine #(
    parameter int NUM_REELS     = 3,
    parameter int SYM_BITS      = 3,
    parameter int CREDIT_W      = 10,
    parameter int START_CREDIT  = 100,
    parameter int MAX_BET       = 3,
    parameter int SPIN_TICKS    = 16,
    parameter int STAGGER_TICKS = 8,
    parameter int PAIR_MULT     = 2,
    parameter int ALL_MULT      = 10,
    parameter int JACKPOT_MULT  = 50
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic                          spin,
    input  logic                          bet_up,
    input  logic                          bet_down,
`ifdef AUTO_SPIN_EN
    input  logic                          auto,
`endif
    output logic [NUM_REELS*SYM_BITS-1:0] reels,
    output logic [NUM_REELS-1:0]          stopped,
    output logic [CREDIT_W-1:0]           credit,
    output logic [2:0]                    bet,
    output logic                          busy,
    output logic                          win,
    output logic [CREDIT_W-1:0]           payout
);

    localparam int CNT_MAX = SPIN_TICKS + (NUM_REELS - 1) * STAGGER_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PW      = CREDIT_W + 6;
    localparam logic [CREDIT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {IDLE, SPIN, EVAL} state_t;

    state_t                             state, state_nxt;
    logic [15:0]                        lfsr;
    logic [CNT_W-1:0]                   cnt;
    logic [CNT_W-1:0]                   cnt_nxt;
    logic [NUM_REELS-1:0][SYM_BITS-1:0] reel_q;
    logic [CREDIT_W-1:0]                bet_ext;
    logic                               can_pay;
    logic                               spin_req;
    logic                               start;
    logic                               auto_go;
    logic                               all_eq;
    logic                               any_pair;
    logic [PW-1:0]                      pay_wide;
    logic [PW:0]                        sum_wide;
    logic [CREDIT_W-1:0]                credit_sat;
    logic [CREDIT_W-1:0]                pay_clip;

    assign reels   = reel_q;
    assign bet_ext = {{(CREDIT_W-3){1'b0}}, bet};
    assign can_pay = credit >= bet_ext;
    assign cnt_nxt = cnt + CNT_W'(1);

    // Fibonacci taps 16,14,13,11 in right-shift form; seed is non-zero so it never locks up
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

`ifdef AUTO_SPIN_EN
    logic [2:0] idle_cnt;

    // counts ticks spent in IDLE with auto held; cleared outside IDLE so each return restarts the wait
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        idle_cnt <= '0;
        else if (state != IDLE || !auto)   idle_cnt <= '0;
        else if (tick && idle_cnt != 3'd4) idle_cnt <= idle_cnt + 3'd1;
    end

    assign auto_go = auto && (idle_cnt == 3'd4);
`else
    assign auto_go = 1'b0;
`endif

    assign spin_req = spin | auto_go;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (spin_req && can_pay) state_nxt = SPIN;
            SPIN:    if (&stopped)            state_nxt = EVAL;
            EVAL:                             state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        start = (state == IDLE) && spin_req && can_pay;
    end

    always_comb begin
        all_eq   = 1'b1;
        any_pair = 1'b0;
        for (int i = 1; i < NUM_REELS; i++) begin
            if (reel_q[i] != reel_q[0])   all_eq   = 1'b0;
            if (reel_q[i] == reel_q[i-1]) any_pair = 1'b1;
        end
        if (all_eq && reel_q[0] == {SYM_BITS{1'b1}})
            pay_wide = PW'(bet) * PW'(JACKPOT_MULT);
        else if (all_eq)
            pay_wide = PW'(bet) * PW'(ALL_MULT);
        else if (any_pair)
            pay_wide = PW'(bet) * PW'(PAIR_MULT);
        else
            pay_wide = '0;
        sum_wide   = {{(PW+1-CREDIT_W){1'b0}}, credit} + {1'b0, pay_wide};
        credit_sat = (sum_wide > {{(PW+1-CREDIT_W){1'b0}}, CMAX}) ? CMAX : sum_wide[CREDIT_W-1:0];
        pay_clip   = (pay_wide > {6'b0, CMAX}) ? CMAX : pay_wide[CREDIT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit  <= CREDIT_W'(START_CREDIT);
            bet     <= 3'd1;
            reel_q  <= '0;
            stopped <= '1;
            cnt     <= '0;
            win     <= 1'b0;
            payout  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        credit  <= credit - bet_ext;
                        win     <= 1'b0;
                        payout  <= '0;
                        stopped <= '0;
                        cnt     <= '0;
                    end else if (bet_up && !bet_down && bet < 3'(MAX_BET)) begin
                        bet <= bet + 3'd1;
                    end else if (bet_down && !bet_up && bet > 3'd1) begin
                        bet <= bet - 3'd1;
                    end
                end
                SPIN: begin
                    if (tick && !(&stopped)) begin
                        cnt <= cnt_nxt;
                        for (int i = 0; i < NUM_REELS; i++) begin
                            if (!stopped[i]) begin
                                if (cnt_nxt == CNT_W'(SPIN_TICKS + i * STAGGER_TICKS)) begin
                                    reel_q[i]  <= lfsr[SYM_BITS-1:0];
                                    stopped[i] <= 1'b1;
                                end else begin
                                    reel_q[i] <= reel_q[i] + SYM_BITS'(1);
                                end
                            end
                        end
                    end
                end
                EVAL: begin
                    credit <= credit_sat;
                    payout <= pay_clip;
                    win    <= (pay_wide != '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/slot_reel_engine.md
Name: slot_reel_engine

Overview:
- Parametrised N-reel spin/score core for the slot machine.
- Replaces the fixed three-reel logic inside the display path with one engine that owns credits, bet, reel symbols and payout.
- Sits between the debounced/edge-detected buttons plus the master_clock spin enable, and the display/sound blocks.
- Reels stop in a staggered sequence, each taking a pseudo-random symbol; the engine then scores the result and updates credits.

Parameters:
NUM_REELS, 3, number of reels (2..8)
SYM_BITS, 3, bits per reel symbol (2^SYM_BITS symbols, 1..8)
CREDIT_W, 10, credit/payout width
START_CREDIT, 100, credit value after reset
MAX_BET, 3, maximum bet (1..7)
SPIN_TICKS, 16, ticks until reel 0 stops
STAGGER_TICKS, 8, extra ticks between successive reel stops
PAIR_MULT, 2, payout multiplier for any adjacent pair
ALL_MULT, 10, payout multiplier for all reels equal
JACKPOT_MULT, 50, payout multiplier for all reels equal to the all-ones symbol

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
tick  input  1  single-cycle spin-rate enable (from master_clock)
spin  input  1  single-cycle spin request
bet_up  input  1  single-cycle bet increment
bet_down  input  1  single-cycle bet decrement
reels  output  NUM_REELS*SYM_BITS  reel symbols, reel 0 in LSBs
stopped  output  NUM_REELS  per-reel stopped flag
credit  output  CREDIT_W  current credits
bet  output  3  current bet
busy  output  1  high from spin accept until scoring completes
win  output  1  last spin paid > 0 (held until next spin)
payout  output  CREDIT_W  last spin payout (held until next spin)

Behaviour:
- Reset (async, reset=0) values:
  - credit=START_CREDIT, bet=1, reels=0, stopped=all ones.
  - busy=0, win=0, payout=0, state=IDLE.
  - LFSR=16'hACE1, tick counter=0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clk cycle in all states; never zero.
- States: IDLE, SPIN, EVAL.
- IDLE:
  - bet_up: bet+1, saturating at MAX_BET.
  - bet_down: bet-1, saturating at 1.
  - bet_up and bet_down in the same cycle: no change.
  - spin with credit>=bet:
    - credit<=credit-bet; win<=0; payout<=0; stopped<=0; counter<=0; busy<=1; go to SPIN.
    - busy is visible the cycle after the spin pulse.
  - spin with credit<bet: ignored; all state unchanged.
  - spin and bet_up/bet_down in the same cycle: the spin uses the current bet; the bet change is dropped.
- SPIN:
  - bet_up, bet_down and spin are ignored.
  - On each tick, the counter increments and each unstopped reel advances its symbol by 1 (mod 2^SYM_BITS).
  - Reel i stops on the tick where the new counter value equals SPIN_TICKS+i*STAGGER_TICKS.
    - At that tick the reel loads lfsr[SYM_BITS-1:0] instead of incrementing, and stopped[i]<=1.
    - With defaults, reels stop on ticks 16, 24 and 32.
  - Counter width: clog2(SPIN_TICKS+(NUM_REELS-1)*STAGGER_TICKS+1).
  - The cycle after the last reel stops, go to EVAL.
- EVAL (exactly one cycle), priority order:
  1. All reels equal to the all-ones symbol: payout=bet*JACKPOT_MULT.
  2. All reels equal: payout=bet*ALL_MULT.
  3. Any adjacent pair i,i+1 equal: payout=bet*PAIR_MULT.
  4. Otherwise payout=0.
  - Products are computed at CREDIT_W+6 bits.
  - credit<=min(credit+payout, 2^CREDIT_W-1), saturating.
  - payout output is clipped to 2^CREDIT_W-1.
  - win<=(payout!=0); busy<=0; go to IDLE.
- tick asserted in the same cycle as the spin accept is not counted.
- Reset asserted mid-spin returns all outputs to reset values immediately; no payout.

Optional Feature:
- AUTO_SPIN_EN defined:
  - Adds input port auto (1 bit).
  - While auto=1 in IDLE with credit>=bet, the engine self-starts a spin after 4 ticks spent in IDLE; the counter resets on each entry to IDLE.
  - Manual spin still works while auto=1.
  - auto=0 clears the idle counter.
- AUTO_SPIN_EN undefined: no auto port; spins start only from spin.

Test Plan:
- Reset:
  - Stimulus: assert reset=0 mid-run.
  - Response: credit=100, bet=1, reels=0, stopped=3'b111, busy=0, win=0.
  - Release, then 3 bet_up pulses -> bet=3; 5 bet_down pulses -> bet=1; bet_up+bet_down in the same cycle -> bet unchanged.
- Basic spin:
  - Stimulus: bet=2, spin, then a tick every 10 clks.
  - Response: credit 100->98 one cycle after spin; stopped bits set on ticks 16, 24, 32; busy falls 2 clks after tick 32.
  - Symbols and payout match the LFSR reference model.
- Insufficient credit:
  - Stimulus: START_CREDIT=1, bet=2, spin.
  - Response: no state change, busy stays 0.
  - Then bet=1, spin -> accepted, credit=0.
- Ignored inputs / saturation:
  - Stimulus: bet_up and spin pulsed during SPIN.
  - Response: no effect.
  - Separately, force all reels to 3'b111 with bet=3, CREDIT_W=8, credit=200 -> payout=150, credit saturates at 255, win=1.
- Reset mid-spin:
  - Stimulus: reset=0 at tick 20.
  - Response: busy=0, credit=100, no EVAL cycle.
  - The next spin starts cleanly from counter 0.
- AUTO_SPIN_EN:
  - Stimulus: auto=1 with credit 100.
  - Response: a new spin starts 4 ticks after each return to IDLE.
  - auto=0 stops further spins.
